// File: rtl/fastio_pkg.sv
// Shared field layout for the fastio bus words of the aux/GPS UART receive FIFO.
//   - RX FIFO entry: 11 bits {break, ferr, perr, data[7:0]}
//   - Data word:     {20'h0, break, ferr, perr, empty, data[7:0]}
//   - Status word:   {ovfl, 15'h0, lgflen[3:0], 1'b0, fill[10:0]}
package fastio_pkg;

    localparam int RXFIFO_ENTRY_W    = 11;

    // Entry-field bit positions
    localparam int ENTRY_PERR_BIT    = 8;
    localparam int ENTRY_FERR_BIT    = 9;
    localparam int ENTRY_BREAK_BIT   = 10;

    // Data-word field positions
    localparam int RXFIFO_EMPTY_BIT  = 8;
    localparam int DATA_PERR_BIT     = 9;
    localparam int DATA_FERR_BIT     = 10;
    localparam int DATA_BREAK_BIT    = 11;

    // Status-word field offsets
    localparam int STATUS_FILL_LSB   = 0;
    localparam int STATUS_FILL_W     = 11;
    localparam int STATUS_LGFLEN_LSB = 12;
    localparam int STATUS_OVFL_BIT   = 31;

    // Data word presented when a read finds nothing to pop
    localparam logic [31:0] RXFIFO_DATA_EMPTY = 32'h0000_0100;

    // Build the data word for a popped (valid) entry.
    function automatic logic [31:0] rx_data_word(input logic [RXFIFO_ENTRY_W-1:0] entry);
        logic [31:0] w;
        w                   = '0;
        w[7:0]              = entry[7:0];
        w[DATA_PERR_BIT]    = entry[ENTRY_PERR_BIT];
        w[DATA_FERR_BIT]    = entry[ENTRY_FERR_BIT];
        w[DATA_BREAK_BIT]   = entry[ENTRY_BREAK_BIT];
        return w;
    endfunction

    // Build the status word.
    function automatic logic [31:0] rx_status_word(input logic ovfl, input logic [3:0] lgflen,
                                                   input logic [STATUS_FILL_W-1:0] fill);
        logic [31:0] w;
        w                                     = '0;
        w[STATUS_OVFL_BIT]                    = ovfl;
        w[STATUS_LGFLEN_LSB +: 4]             = lgflen;
        w[STATUS_FILL_LSB +: STATUS_FILL_W]   = fill;
        return w;
    endfunction

endpackage

// File: rtl/rxfifo_mem.sv
// Simple dual-port RAM for the RX FIFO, 2^LGFLEN x WIDTH, registered read.
// Ports:
//   i_clk             clock
//   i_we/i_waddr/i_wdata   synchronous write port
//   i_re/i_raddr      read enable/address; o_rdata updates on the edge after i_re
//   o_rdata           registered read data (read-before-write on address collision)
module rxfifo_mem #(
    parameter int LGFLEN = 4,
    parameter int WIDTH  = 11
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [LGFLEN-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [LGFLEN-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] mem [2**LGFLEN];

    // NOTE: storage and its read register carry no reset so the array maps onto
    // distributed RAM; the top masks o_rdata until a real pop has loaded it.
    always_ff @(posedge i_clk) begin
        if (i_we)
            mem[i_waddr] <= i_wdata;
        // A pop on a full FIFO reads the slot being rewritten; this returns the old entry.
        if (i_re)
            o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/rxuart_fifo.sv
// Receive-side FIFO between rxuart and the fastio bus for the aux/GPS UART.
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_rx_stb            one-cycle strobe: i_rx_data/break/ferr/perr are valid
//   i_rd                bus read of the data word; pops one entry
//   i_clr               bus write of the status word; clears the sticky overflow flag
//   o_data              {20'h0, break, ferr, perr, empty, byte}, registered, pop-on-read
//   o_status            {ovfl, 15'h0, LGFLEN, 1'b0, fill}, registered every cycle
//   o_int               half-full, idle-data or overflow interrupt, registered
module rxuart_fifo
    import fastio_pkg::*;
#(
    parameter int          LGFLEN      = 4,
    parameter logic [23:0] IDLE_CYCLES = 24'd20000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_stb,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_break,
    input  logic        i_rx_ferr,
    input  logic        i_rx_perr,
    input  logic        i_rd,
    input  logic        i_clr,
    output logic [31:0] o_data,
    output logic [31:0] o_status,
    output logic        o_int
);

    logic [LGFLEN-1:0]         wr_ptr, rd_ptr;
    logic [LGFLEN:0]           fill;
    logic                      ovfl;
    logic [23:0]               idle_cnt;
    logic                      rd_valid;
    logic [RXFIFO_ENTRY_W-1:0] rd_entry;
    logic [RXFIFO_ENTRY_W-1:0] wr_entry;
    logic                      full, empty, half, idle;
    logic                      push, pop, ovfl_event;

    // fill never exceeds 2^LGFLEN, so its MSB alone marks full, and
    // fill >= 2^(LGFLEN-1) is exactly "either of the top two bits set".
    assign full       = fill[LGFLEN];
    assign empty      = (fill == '0);
    assign half       = fill[LGFLEN] | fill[LGFLEN-1];
    assign idle       = (idle_cnt == IDLE_CYCLES);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte when read.
    assign pop        = i_rd && !empty;
    assign push       = i_rx_stb && (!full || i_rd);
    assign ovfl_event = i_rx_stb && full && !i_rd;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_entry                  = '0;
        wr_entry[7:0]             = i_rx_data;
        wr_entry[ENTRY_PERR_BIT]  = i_rx_perr;
        wr_entry[ENTRY_FERR_BIT]  = i_rx_ferr;
        wr_entry[ENTRY_BREAK_BIT] = i_rx_break;
    end

    rxfifo_mem #(
        .LGFLEN (LGFLEN),
        .WIDTH  (RXFIFO_ENTRY_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr),
        .i_wdata (wr_entry),
        .i_re    (pop),
        .i_raddr (rd_ptr),
        .o_rdata (rd_entry)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            ovfl     <= 1'b0;
            idle_cnt <= '0;
            rd_valid <= 1'b0;
            o_int    <= 1'b0;
            o_status <= rx_status_word(1'b0, 4'(LGFLEN), '0);
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase

            // Overflow set wins over a simultaneous clear.
            if (ovfl_event)
                ovfl <= 1'b1;
            else if (i_clr)
                ovfl <= 1'b0;

            if (push || empty)
                idle_cnt <= '0;
            else if (!idle)
                idle_cnt <= idle_cnt + 1'b1;

            // Read data is only refreshed by i_rd; otherwise the last word is held.
            if (i_rd)
                rd_valid <= pop;

            o_int    <= half || idle || ovfl;
            o_status <= rx_status_word(ovfl, 4'(LGFLEN), STATUS_FILL_W'(fill));
        end
    end

    assign o_data = rd_valid ? rx_data_word(rd_entry) : RXFIFO_DATA_EMPTY;

endmodule

// File: tb/tb_rxuart_fifo.sv
// Self-checking bench for rxuart_fifo: directed scenarios followed by a random
// phase, all compared every cycle against a queue-based reference model.
module tb_rxuart_fifo;

    localparam int          LGFLEN = 4;
    localparam int          DEPTH  = 2**LGFLEN;
    localparam int          IDLE   = 10;
    localparam logic [31:0] ST0    = 32'h0000_4000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx_stb = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_break = 1'b0;
    logic        i_rx_ferr = 1'b0;
    logic        i_rx_perr = 1'b0;
    logic        i_rd = 1'b0;
    logic        i_clr = 1'b0;
    logic [31:0] o_data;
    logic [31:0] o_status;
    logic        o_int;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [10:0] q[$];
    logic        m_ovfl = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_data   = 32'h100;
    logic [31:0] m_status = ST0;
    logic        m_int    = 1'b0;

    rxuart_fifo #(
        .LGFLEN      (LGFLEN),
        .IDLE_CYCLES (24'(IDLE))
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_stb   (i_rx_stb),
        .i_rx_data  (i_rx_data),
        .i_rx_break (i_rx_break),
        .i_rx_ferr  (i_rx_ferr),
        .i_rx_perr  (i_rx_perr),
        .i_rd       (i_rd),
        .i_clr      (i_clr),
        .o_data     (o_data),
        .o_status   (o_status),
        .o_int      (o_int)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovfl   = 1'b0;
        m_cnt    = 0;
        m_data   = 32'h100;
        m_status = ST0;
        m_int    = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using pre-edge state.
    function automatic void model_edge(input logic stb, input logic [10:0] ent,
                                       input logic rd, input logic clr);
        int          sz;
        bit          accepted;
        logic [10:0] e;
        sz       = q.size();
        accepted = stb && (sz < DEPTH || rd);
        m_int    = (sz >= DEPTH/2) || (m_cnt >= IDLE) || m_ovfl;
        m_status = {m_ovfl, 15'h0, 4'(LGFLEN), 1'b0, 11'(sz)};
        if (rd) begin
            if (sz > 0) begin
                e      = q.pop_front();
                m_data = {20'h0, e[10:8], 1'b0, e[7:0]};
            end else begin
                m_data = 32'h100;
            end
        end
        if (accepted)
            q.push_back(ent);
        if (stb && sz == DEPTH && !rd)
            m_ovfl = 1'b1;
        else if (clr)
            m_ovfl = 1'b0;
        if (accepted || sz == 0)
            m_cnt = 0;
        else if (m_cnt < IDLE)
            m_cnt++;
    endfunction

    // Drive one cycle, advance the model, then compare all outputs #1 after the edge.
    task automatic step(input logic stb, input logic [10:0] ent, input logic rd, input logic clr);
        i_rx_stb   = stb;
        i_rx_data  = ent[7:0];
        i_rx_perr  = ent[8];
        i_rx_ferr  = ent[9];
        i_rx_break = ent[10];
        i_rd       = rd;
        i_clr      = clr;
        @(posedge i_clk);
        model_edge(stb, ent, rd, clr);
        #1;
        i_rx_stb = 1'b0;
        i_rd     = 1'b0;
        i_clr    = 1'b0;
        check("o_data",   o_data,   m_data);
        check("o_status", o_status, m_status);
        check("o_int",    {31'h0, o_int}, {31'h0, m_int});
    endtask

    task automatic wr(input logic [10:0] ent);
        step(1'b1, ent, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 11'h0, 1'b1, 1'b0);
    endtask

    task automatic idle_step();
        step(1'b0, 11'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        #22;
        i_rst = 1'b0;
        model_reset();
        check("rst_data",   o_data,   32'h100);
        check("rst_status", o_status, ST0);
        check("rst_int",    {31'h0, o_int}, 32'h0);

        // Read of an empty FIFO
        rd();
        check("empty_rd", o_data, 32'h100);

        // Two bytes, then three reads
        wr(11'h041);
        wr(11'h042);
        rd();
        check("rd_41", o_data, 32'h041);
        rd();
        check("rd_42", o_data, 32'h042);
        rd();
        check("rd_empty", o_data, 32'h100);

        // Half-full interrupt, full, overflow, ordered drain, clear
        for (int i = 0; i < 8; i++)
            wr(11'(i));
        check("int_lag", {31'h0, o_int}, 32'h0);
        idle_step();
        check("int_half", {31'h0, o_int}, 32'h1);
        for (int i = 8; i < 16; i++)
            wr(11'(i));
        idle_step();
        check("fill_16", o_status, 32'h0000_4010);
        wr(11'h0EE);
        idle_step();
        check("ovfl_set", o_status, 32'h8000_4010);
        for (int i = 0; i < 16; i++) begin
            rd();
            check("drain_order", o_data, 32'(i));
        end
        step(1'b0, 11'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            idle_step();
        check("clr_status", o_status, ST0);
        check("clr_int", {31'h0, o_int}, 32'h0);

        // Full FIFO with simultaneous pop and write
        for (int i = 0; i < 16; i++)
            wr(11'(8'h80 + i));
        step(1'b1, 11'h099, 1'b1, 1'b0);
        check("full_rdwr_data", o_data, 32'h080);
        idle_step();
        check("full_rdwr_status", o_status, 32'h0000_4010);
        for (int i = 1; i < 16; i++) begin
            rd();
            check("full_rdwr_drain", o_data, 32'(8'h80 + i));
        end
        rd();
        check("full_rdwr_last", o_data, 32'h099);

        // Idle timer: interrupt exactly 11 cycles after a lone write
        for (int i = 0; i < 3; i++)
            idle_step();
        wr(11'h25A);
        for (int i = 0; i < 10; i++)
            idle_step();
        check("idle_before", {31'h0, o_int}, 32'h0);
        idle_step();
        check("idle_fire", {31'h0, o_int}, 32'h1);
        rd();
        check("ferr_data", o_data, 32'h45A);
        for (int i = 0; i < 3; i++)
            idle_step();
        check("idle_drop", {31'h0, o_int}, 32'h0);

        // Asynchronous reset with entries stored and a pop in flight
        for (int i = 0; i < 5; i++)
            wr(11'(8'hC0 + i));
        rd();
        check("pre_rst_data", o_data, 32'h0C0);
        i_rd = 1'b1;
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_data",   o_data,   32'h100);
        check("async_rst_status", o_status, ST0);
        check("async_rst_int",    {31'h0, o_int}, 32'h0);
        i_rd = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        rd();
        check("post_rst_rd", o_data, 32'h100);

        // Random phase against the model
        for (int n = 0; n < 600; n++) begin
            logic        stb, r, c;
            logic [10:0] ent;
            stb = ($urandom_range(0, 9) < ((n < 300) ? 7 : 3));
            r   = ($urandom_range(0, 9) < 4);
            c   = ($urandom_range(0, 19) == 0);
            ent = 11'($urandom_range(0, 2047));
            step(stb, ent, r, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rxuart_fifo.md
Name: rxuart_fifo

Overview:
- Receive-side buffer between an `rxuart` instance and the fastio bus register for the aux/GPS UART receive port.
- Captures every received byte, together with its break, framing and parity flags, into a power-of-two FIFO.
- Software drains the FIFO through a pop-on-read data word and monitors it through a status word.
- Raises an interrupt when the FIFO is half full, or when data has sat unread for a programmable idle time.

Parameters:
- LGFLEN, 4: log2 of FIFO depth; depth = 2^LGFLEN entries (legal range 2..10).
- IDLE_CYCLES, 24'd20000: cycles with no new byte and a non-empty FIFO before the idle interrupt asserts.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_rx_stb  in  1  one-cycle strobe from rxuart: new byte present.
- i_rx_data  in  8  received byte.
- i_rx_break  in  1  break flag, qualified by i_rx_stb.
- i_rx_ferr  in  1  framing-error flag, qualified by i_rx_stb.
- i_rx_perr  in  1  parity-error flag, qualified by i_rx_stb.
- i_rd  in  1  bus read strobe of the data address; pops one entry.
- i_clr  in  1  bus write strobe of the status address; clears the overflow flag.
- o_data  out  32  {20'h0, break, ferr, perr, empty, byte[7:0]}; empty=1 means no valid byte.
- o_status  out  32  {ovfl, 15'h0, 4'(LGFLEN), 1'b0, fill[10:0]}.
- o_int  out  1  interrupt request.

Behaviour:
- Reset (async):
  - write/read pointers=0, fill=0, ovfl=0, idle counter=0.
  - o_data=32'h0000_0100, o_int=0.
  - Memory contents are don't-care.
  - Reset mid-transfer discards all stored entries.
- Entry format: 11 bits {break, ferr, perr, data}.
- Write:
  - On i_rx_stb with fill < 2^LGFLEN: store the entry at the write pointer, advance the write pointer mod depth, fill+1.
  - On i_rx_stb with the FIFO full and no simultaneous pop: drop the byte, set ovfl=1 (sticky).
  - Full with a simultaneous i_rd: the pop and the write both occur, fill unchanged, no overflow.
- Read / pop:
  - o_data is registered. On the cycle after i_rd it holds the entry popped by that read, with empty=0.
  - If the FIFO was empty at i_rd, o_data becomes 32'h100 (empty=1, other fields 0).
  - Empty FIFO with i_rd and i_rx_stb in the same cycle: the read returns empty; the byte is stored (fill=1).
  - Without i_rd, o_data holds its last value; data is never re-presented.
- Pointers:
  - Both pointers are LGFLEN bits and wrap naturally.
  - fill is (LGFLEN+1) bits, zero-extended to 11 bits in o_status.
  - full is fill==2^LGFLEN; empty is fill==0.
- Overflow clear: i_clr sets ovfl=0. If i_clr coincides with an overflow event, ovfl ends at 1 (set wins).
- Idle timer:
  - Counter resets to 0 on any accepted write or whenever the FIFO is empty.
  - Otherwise it increments, saturating at IDLE_CYCLES.
  - idle = (counter == IDLE_CYCLES).
- Interrupt:
  - o_int is registered: o_int <= (fill >= 2^(LGFLEN-1)) || idle || ovfl.
  - It therefore lags the causing state change by one cycle.
- o_status is registered, updated every cycle, one-cycle latency, consistent with the fastio read-mux timing.
- All reads are side-effect free except i_rd, which pops.

Decomposition:
- Shared package (fastio_pkg):
  - RXFIFO_EMPTY_BIT = 8.
  - Entry-field bit positions.
  - Status-word field offsets.
- One natural sub-module: `rxfifo_mem`, a simple dual-port RAM (2^LGFLEN x 11, registered read) so synthesis infers distributed RAM.
- Pointer, fill, idle and interrupt logic stay in `rxuart_fifo`.

Test Plan:
- Reset, then i_rd with no input -> o_data=32'h100, o_status fill=0, ovfl=0, o_int=0.
- Write bytes 8'h41 and 8'h42 (flags 0), then two i_rd pulses -> o_data=32'h041, then 32'h042; third i_rd -> 32'h100.
- LGFLEN=4: write 8 bytes -> o_int=1 one cycle after the 8th write. Write 8 more (16) -> fill=16. 17th write -> ovfl=1, byte dropped. Drain 16 -> data in order 0..15. i_clr -> ovfl=0, o_int=0.
- Full FIFO with i_rd and i_rx_stb in the same cycle -> fill stays 16, ovfl stays 0, new byte appears last on drain.
- IDLE_CYCLES=10: write one byte with ferr=1 and no further input -> o_int=1 exactly 11 cycles after the write. i_rd -> o_data=32'h400|byte. o_int drops after the FIFO empties.
- Assert i_rst asynchronously with 5 entries stored and a pop in flight -> outputs return to reset values immediately; the next i_rd returns 32'h100.
